// File: rtl/arbitro_de_sequencias.sv
// Collects one-cycle A/B sequence indications into pending flags, arbitrates them
// round-robin into a first-word-fall-through FIFO, and keeps saturating counters plus a loss flag.
module arbitro_de_sequencias #(
    parameter int PROF      = 4,
    parameter int LARG_CONT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seq_a,
    input  logic                 seq_b,
    input  logic                 habilita,
    input  logic                 evt_ready,
    input  logic                 limpa_perdido,
    output logic                 evt_valid,
    output logic                 evt_tipo,
    output logic [LARG_CONT-1:0] cont_a,
    output logic [LARG_CONT-1:0] cont_b,
    output logic                 perdido
);

    localparam int PW = $clog2(PROF);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } fonte_t;

    fonte_t         ultimo;
    logic           pend_a;
    logic           pend_b;
    logic           mem [PROF];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    ocup;

    logic acc_a, acc_b, cheio, pop, push;
    logic grant_a, grant_b, perda;

    always_comb begin
        acc_a   = seq_a & habilita;
        acc_b   = seq_b & habilita;
        // Occupancy never exceeds PROF (a power of 2), so the top bit alone means full.
        cheio   = ocup[PW];
        evt_valid = (ocup != '0);
        evt_tipo  = evt_valid & mem[rd_ptr];
        pop     = evt_valid & evt_ready;
        grant_a = !cheio && pend_a && (!pend_b || ultimo == SRC_B);
        grant_b = !cheio && pend_b && (!pend_a || ultimo == SRC_A);
        push    = grant_a | grant_b;
        perda   = (acc_a && pend_a && !grant_a) || (acc_b && pend_b && !grant_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
            ultimo  <= SRC_B;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ocup    <= '0;
            cont_a  <= '0;
            cont_b  <= '0;
            perdido <= 1'b0;
        end else begin
            pend_a <= acc_a | (pend_a & !grant_a);
            pend_b <= acc_b | (pend_b & !grant_b);
            if (grant_a) begin
                ultimo <= SRC_A;
            end else if (grant_b) begin
                ultimo <= SRC_B;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   ocup <= ocup + (PW+1)'(1);
                2'b01:   ocup <= ocup - (PW+1)'(1);
                default: ocup <= ocup;
            endcase
            if (acc_a && cont_a != '1) begin
                cont_a <= cont_a + LARG_CONT'(1);
            end
            if (acc_b && cont_b != '1) begin
                cont_b <= cont_b + LARG_CONT'(1);
            end
            // A loss in the same cycle takes priority over the clear request.
            if (perda) begin
                perdido <= 1'b1;
            end else if (limpa_perdido) begin
                perdido <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= grant_b;
        end
    end

endmodule

// File: doc/arbitro_de_sequencias.md
# arbitro_de_sequencias

Collects the one-cycle `seq_a` / `seq_b` indications produced by the pulse-sequence detector and holds them in per-source pending flags. A round-robin arbiter moves them into a small FIFO, and a downstream consumer drains the FIFO through a valid/ready handshake. The block also keeps saturating per-source event counters and a sticky loss flag. It sits between the detector and the system-level consumer, for example a serial reporter or an interrupt controller.

## Interface
- `PROF`, 4, FIFO depth in entries; power of 2, at least 2.
- `LARG_CONT`, 8, width of each event counter.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `seq_a` in 1: one-cycle indication that an A sequence was detected.
- `seq_b` in 1: one-cycle indication that a B sequence was detected.
- `habilita` in 1: when low, incoming indications are ignored.
- `evt_ready` in 1: consumer accepts the head event.
- `limpa_perdido` in 1: clears `perdido`.
- `evt_valid` out 1: FIFO not empty.
- `evt_tipo` out 1: head event source; 0 = A, 1 = B.
- `cont_a` out LARG_CONT: saturating count of accepted A indications.
- `cont_b` out LARG_CONT: saturating count of accepted B indications.
- `perdido` out 1: sticky flag; at least one indication was dropped.

## Operation
- **Reset (async, immediate):**
  - `pend_a` = `pend_b` = 0.
  - FIFO empty, so `evt_valid` = 0 and `evt_tipo` = 0.
  - `cont_a` = `cont_b` = 0, `perdido` = 0.
  - `ultimo` = 1, so A wins the first tie.
- **Input capture** (per source x, sampled at each rising edge):
  - An indication is accepted when `seq_x` = 1 and `habilita` = 1.
  - An accepted indication sets `pend_x` and increments `cont_x`.
  - `cont_x` saturates at 2^LARG_CONT-1. Dropped indications are still counted.
- **Loss:**
  - An accepted indication that arrives while `pend_x` = 1 and `pend_x` is not granted in the same cycle sets `perdido`.
  - `pend_x` stays 1 in that case (the two events merge).
- **Arbitration** (each cycle, when the FIFO is not full):
  - Only one pending flag set: that source is granted.
  - Both set: grant the source != `ultimo`.
  - A grant writes the source code into the FIFO, clears that `pend`, and sets `ultimo` to the granted source.
  - Grant-clear and a new accepted indication on the same source in the same cycle: `pend` stays 1 and no loss is flagged.
- **FIFO full:**
  - No grant. Pending flags hold and `ultimo` is unchanged.
  - "Full" is evaluated on occupancy before this cycle's pop, so a pop does not free a slot in the same cycle.
- **Output:**
  - The FIFO is first-word-fall-through.
  - A pop happens on a rising edge where `evt_valid` & `evt_ready`.
  - `evt_tipo` is stable while `evt_valid` = 1 and `evt_ready` = 0.
  - Simultaneous push and pop when not full: occupancy is unchanged.
- **Pointers:** read and write pointers are log2(PROF) bits and wrap modulo PROF. Occupancy is tracked with one extra bit.
- **`limpa_perdido`:** clears `perdido` at the edge. A loss in the same cycle wins, and `perdido` stays 1.
- **`habilita` = 0:** no new captures. Pending flags and the FIFO continue to drain.

## Timing
- Indication sampled at edge k: `pend_x` = 1 after edge k.
- FIFO write at edge k+1 (if granted), so `evt_valid` = 1 after edge k+1. The latency is 2 edges from a `seq_x` high cycle to visible `evt_valid`.
- `cont_x` updates after edge k. `perdido` updates after the edge on which the loss occurs.
- Throughput: one FIFO write and one FIFO read per cycle.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.
- Reset asserted mid-operation discards the pending flags, the FIFO contents and the counters immediately. Operation restarts on the first edge after deassertion.

## Test plan
- **Single A event:** `seq_a` pulse at edge 1 with `evt_ready` = 1.
  - `evt_valid` is high after edge 2 with `evt_tipo` = 0.
  - It drops after edge 3.
  - `cont_a` = 1 and `perdido` = 0.
- **Tie and round-robin:** `seq_a` and `seq_b` in the same cycle twice in a row, with `evt_ready` = 0.
  - The FIFO order is A, B, then B merged into pending.
  - Expected end state: `perdido` = 1, `cont_a` = 2, `cont_b` = 2.
- **Back-pressure with PROF = 4:** six spaced A pulses with `evt_ready` = 0.
  - FIFO holds 4 and `pend_a` = 1; the 6th pulse sets `perdido`.
  - Then raise `evt_ready`: exactly five A events are delivered.
- **Counter saturation with LARG_CONT = 2:** five B pulses.
  - `cont_b` counts 1, 2, 3 and stays at 3.
- **`habilita` = 0:** three A pulses.
  - No events delivered and `cont_a` = 0.
  - Then `limpa_perdido` together with a forced loss in the same cycle: `perdido` stays 1.
- **Async reset mid-stream:** assert `reset` between edges while the FIFO holds 3 events.
  - `evt_valid` = 0, counters = 0 and `perdido` = 0 immediately, without waiting for a clock edge.
  - After release, the first event has latency 2 again.
